// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP opcode, stage-1 state encoding and operand-length decode.
package pipeline_pkg;

   localparam logic [7:0] NOP = 8'h00;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      OPA   = 2'd1,
      OPB   = 2'd2
   } stage1_state_t;

   typedef logic [1:0] oplen_t;

   // Operand byte count lives in opcode[7:6]: 11 -> 2, 10 -> 1, 0x -> 0.
   function automatic oplen_t decodeOpLen(input logic [7:0] opcode);
      case (opcode[7:6])
         2'b11:   return 2'd2;
         2'b10:   return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipeline_stage1_if.sv
// Stage-1 bus bundle: stage-0/memory inputs and stage-2/fetch-suppress outputs.
interface pipeline_stage1_if;

   logic [7:0]  Pipe0In;
   logic [7:0]  MEMDATA;
   logic        BusRequest;
   logic        Flush;
   logic [7:0]  PipeOut;
   logic [15:0] ImmOut;
   logic        Pipe1Out_ImmValid;
   logic        FetchSurpress;

   modport master (
      output Pipe0In, MEMDATA, BusRequest, Flush,
      input  PipeOut, ImmOut, Pipe1Out_ImmValid, FetchSurpress
   );

   modport slave (
      input  Pipe0In, MEMDATA, BusRequest, Flush,
      output PipeOut, ImmOut, Pipe1Out_ImmValid, FetchSurpress
   );

endinterface

// File: rtl/pipe1_oplen_decode.sv
// Combinational opcode-to-operand-count decoder, reused by later pipeline stages.
module pipe1_oplen_decode
   import pipeline_pkg::*;
(
   input  logic [7:0] i_opcode,
   output oplen_t     o_opLen
);

   assign o_opLen = decodeOpLen(i_opcode);

endmodule

// File: rtl/pipeline_stage1.sv
// Pipeline stage 1: assembles opcode plus 0-2 immediate bytes into one instruction.
// Optional flush support is enabled by defining PIPE1_FLUSH_EN.
module pipeline_stage1
   import pipeline_pkg::*;
(
   input  logic              ClockIn,
   input  logic              ResetIn_n,
   pipeline_stage1_if.slave  bus
);

   stage1_state_t r_state, w_nextState;
   logic [7:0]    r_opcode, w_nextOpcode;
   logic [7:0]    r_immLo, w_nextImmLo;
   logic [7:0]    r_pipeOut, w_nextPipeOut;
   logic [15:0]   r_immOut, w_nextImmOut;
   logic          r_immValid, w_nextImmValid;
   logic          r_fetchSuppress, w_nextFetchSuppress;
   logic [7:0]    w_decodeOpcode;
   oplen_t        w_opLen;

`ifndef PIPE1_FLUSH_EN
   logic w_unusedFlush;
   assign w_unusedFlush = bus.Flush;
`endif

   // In FETCH the length comes from the byte arriving now; afterwards from the latched opcode.
   assign w_decodeOpcode = (r_state == FETCH) ? bus.Pipe0In : r_opcode;

   pipe1_oplen_decode u_oplenDecode (
      .i_opcode (w_decodeOpcode),
      .o_opLen  (w_opLen)
   );

   always_comb begin
      w_nextState         = r_state;
      w_nextOpcode        = r_opcode;
      w_nextImmLo         = r_immLo;
      w_nextPipeOut       = r_pipeOut;
      w_nextImmOut        = r_immOut;
      w_nextImmValid      = r_immValid;
      w_nextFetchSuppress = r_fetchSuppress;
`ifdef PIPE1_FLUSH_EN
      if (bus.Flush) begin
         w_nextState         = FETCH;
         w_nextImmLo         = 8'h00;
         w_nextPipeOut       = NOP;
         w_nextImmOut        = 16'h0000;
         w_nextImmValid      = 1'b0;
         w_nextFetchSuppress = 1'b0;
      end else
`endif
      if (!bus.BusRequest) begin
         w_nextPipeOut       = NOP;
         w_nextImmOut        = 16'h0000;
         w_nextImmValid      = 1'b0;
         w_nextFetchSuppress = 1'b0;
         case (r_state)
            FETCH: begin
               w_nextOpcode = bus.Pipe0In;
               if (w_opLen == 2'd0) begin
                  w_nextPipeOut = bus.Pipe0In;
               end else begin
                  w_nextFetchSuppress = 1'b1;
                  w_nextState         = OPA;
               end
            end
            OPA: begin
               w_nextImmLo = bus.MEMDATA;
               if (w_opLen == 2'd2) begin
                  w_nextFetchSuppress = 1'b1;
                  w_nextState         = OPB;
               end else begin
                  w_nextPipeOut  = r_opcode;
                  w_nextImmOut   = {8'h00, bus.MEMDATA};
                  w_nextImmValid = 1'b1;
                  w_nextState    = FETCH;
               end
            end
            OPB: begin
               w_nextPipeOut  = r_opcode;
               w_nextImmOut   = {bus.MEMDATA, r_immLo};
               w_nextImmValid = 1'b1;
               w_nextState    = FETCH;
            end
            default: begin
               w_nextState = FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge ClockIn or negedge ResetIn_n) begin
      if (!ResetIn_n) begin
         r_state         <= FETCH;
         r_opcode        <= 8'h00;
         r_immLo         <= 8'h00;
         r_pipeOut       <= NOP;
         r_immOut        <= 16'h0000;
         r_immValid      <= 1'b0;
         r_fetchSuppress <= 1'b0;
      end else begin
         r_state         <= w_nextState;
         r_opcode        <= w_nextOpcode;
         r_immLo         <= w_nextImmLo;
         r_pipeOut       <= w_nextPipeOut;
         r_immOut        <= w_nextImmOut;
         r_immValid      <= w_nextImmValid;
         r_fetchSuppress <= w_nextFetchSuppress;
      end
   end

   assign bus.PipeOut           = r_pipeOut;
   assign bus.ImmOut            = r_immOut;
   assign bus.Pipe1Out_ImmValid = r_immValid;
   assign bus.FetchSurpress     = r_fetchSuppress;

endmodule

// File: tb/tb_pipeline_stage1.sv
// Directed table-driven bench for pipeline_stage1, plus flush and mid-operand reset sequences.
module tb_pipeline_stage1;

   typedef struct {
      logic [7:0]  pipe0;
      logic [7:0]  mem;
      logic        busReq;
      logic [7:0]  expPipe;
      logic [15:0] expImm;
      logic        expValid;
      logic        expFs;
   } vec_t;

   logic ClockIn = 1'b0;
   logic ResetIn_n = 1'b1;
   int   testsRun = 0;
   int   testsFailed = 0;
   vec_t vecs[$];

   pipeline_stage1_if bus ();

   pipeline_stage1 dut (
      .ClockIn   (ClockIn),
      .ResetIn_n (ResetIn_n),
      .bus       (bus)
   );

   always #5 ClockIn = ~ClockIn;

   task automatic applyStimulus(input logic [7:0] pipe0, input logic [7:0] mem,
                                input logic busReq, input logic flush);
      bus.Pipe0In    = pipe0;
      bus.MEMDATA    = mem;
      bus.BusRequest = busReq;
      bus.Flush      = flush;
   endtask

   task automatic stepClock();
      @(posedge ClockIn);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] expPipe,
                              input logic [15:0] expImm, input logic expValid,
                              input logic expFs);
      testsRun++;
      if (bus.PipeOut !== expPipe || bus.ImmOut !== expImm ||
          bus.Pipe1Out_ImmValid !== expValid || bus.FetchSurpress !== expFs) begin
         testsFailed++;
         $display("[TB] FAIL %s: got pipe=%02h imm=%04h valid=%b fs=%b, expected pipe=%02h imm=%04h valid=%b fs=%b",
                  name, bus.PipeOut, bus.ImmOut, bus.Pipe1Out_ImmValid, bus.FetchSurpress,
                  expPipe, expImm, expValid, expFs);
      end
   endtask

   initial begin
      // Continuous stream: each row is one clock edge, expectations after that edge.
      vecs.push_back('{8'h12, 8'h00, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b0});
      vecs.push_back('{8'h85, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'h3C, 1'b0, 8'h85, 16'h003C, 1'b1, 1'b0});
      vecs.push_back('{8'hC4, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'h34, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'h12, 1'b0, 8'hC4, 16'h1234, 1'b1, 1'b0});
      vecs.push_back('{8'h01, 8'h00, 1'b0, 8'h01, 16'h0000, 1'b0, 1'b0});
      vecs.push_back('{8'h3F, 8'h00, 1'b0, 8'h3F, 16'h0000, 1'b0, 1'b0});
      vecs.push_back('{8'h40, 8'h00, 1'b0, 8'h40, 16'h0000, 1'b0, 1'b0});
      vecs.push_back('{8'hBF, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'hFF, 1'b0, 8'hBF, 16'h00FF, 1'b1, 1'b0});
      vecs.push_back('{8'hFF, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'hAB, 1'b0, 8'hFF, 16'hAB00, 1'b1, 1'b0});
      vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0});
      vecs.push_back('{8'hC4, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'h99, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'h88, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'h34, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'h12, 1'b0, 8'hC4, 16'h1234, 1'b1, 1'b0});
      vecs.push_back('{8'h85, 8'h00, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1});
      vecs.push_back('{8'h00, 8'h3C, 1'b0, 8'h85, 16'h003C, 1'b1, 1'b0});
      vecs.push_back('{8'h12, 8'h00, 1'b1, 8'h85, 16'h003C, 1'b1, 1'b0});
      vecs.push_back('{8'h12, 8'h00, 1'b0, 8'h12, 16'h0000, 1'b0, 1'b0});

      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      #1 ResetIn_n = 1'b0;
      stepClock();
      stepClock();
      checkOutput("resetState", 8'h00, 16'h0000, 1'b0, 1'b0);
      ResetIn_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].pipe0, vecs[i].mem, vecs[i].busReq, 1'b0);
         stepClock();
         checkOutput($sformatf("vec%0d", i), vecs[i].expPipe, vecs[i].expImm,
                     vecs[i].expValid, vecs[i].expFs);
      end

      // Flush asserted together with BusRequest while waiting for the high operand byte.
      applyStimulus(8'hC4, 8'h00, 1'b0, 1'b0);
      stepClock();
      checkOutput("flushSetupOpa", 8'h00, 16'h0000, 1'b0, 1'b1);
      applyStimulus(8'h00, 8'h34, 1'b0, 1'b0);
      stepClock();
      checkOutput("flushSetupOpb", 8'h00, 16'h0000, 1'b0, 1'b1);
      applyStimulus(8'h00, 8'h56, 1'b1, 1'b1);
      stepClock();
`ifdef PIPE1_FLUSH_EN
      checkOutput("flushInOpb", 8'h00, 16'h0000, 1'b0, 1'b0);
      applyStimulus(8'h01, 8'h00, 1'b0, 1'b0);
      stepClock();
      checkOutput("afterFlush", 8'h01, 16'h0000, 1'b0, 1'b0);
`else
      checkOutput("flushIgnoredStall", 8'h00, 16'h0000, 1'b0, 1'b1);
      applyStimulus(8'h00, 8'h12, 1'b0, 1'b1);
      stepClock();
      checkOutput("flushIgnoredEmit", 8'hC4, 16'h1234, 1'b1, 1'b0);
`endif
      applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
      stepClock();
      checkOutput("postFlushNop", 8'h00, 16'h0000, 1'b0, 1'b0);

      // Reset pulse between clock edges while waiting for the 0x85 operand.
      applyStimulus(8'h85, 8'h00, 1'b0, 1'b0);
      stepClock();
      checkOutput("rstSetupOpa", 8'h00, 16'h0000, 1'b0, 1'b1);
      #2 ResetIn_n = 1'b0;
      #1;
      checkOutput("rstAsyncDrop", 8'h00, 16'h0000, 1'b0, 1'b0);
      applyStimulus(8'h00, 8'h3C, 1'b0, 1'b0);
      stepClock();
      checkOutput("rstHeld", 8'h00, 16'h0000, 1'b0, 1'b0);
      ResetIn_n = 1'b1;
      stepClock();
      checkOutput("rstNoEmit", 8'h00, 16'h0000, 1'b0, 1'b0);
      applyStimulus(8'h21, 8'h00, 1'b0, 1'b0);
      stepClock();
      checkOutput("rstRecover", 8'h21, 16'h0000, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pipeline_stage1.md
# pipeline_stage1

Pipeline stage 1 sits directly downstream of the stage-0 fetch register. It consumes the fetched opcode byte and the raw memory byte, then assembles 1- to 3-byte instructions (opcode plus 0–2 immediate operand bytes). It drives the fetch-suppress line back into stage 0 while operand bytes are in flight, and presents a complete instruction to stage 2 in a single cycle.

## Interface
- No parameters; all widths are fixed (8-bit opcode, 16-bit immediate).
- ClockIn  in  1  system clock; all state updates on the rising edge.
- ResetIn_n  in  1  reset, asynchronous assert, active-low.
- Pipe0In  in  8  opcode byte from stage 0 (stage 0 presents 0x00 while suppressed).
- MEMDATA  in  8  memory data bus; operand bytes are sampled here.
- BusRequest  in  1  stall: while high, every register holds its value.
- Flush  in  1  branch/abort: discard the partial instruction and emit NOP.
- PipeOut  out  8  opcode to stage 2; 0x00 (NOP) when no instruction completes.
- ImmOut  out  16  immediate for the emitted instruction, zero-extended.
- Pipe1Out_ImmValid  out  1  high when PipeOut carries an instruction with at least one operand.
- FetchSurpress  out  1  to stage 0; high while the next byte fetched is an operand.

## Operation
- Operand length comes from opcode[7:6]:
  - 2'b11 means 2 operand bytes.
  - 2'b10 means 1 operand byte.
  - 2'b0x means 0 operand bytes.
- The state machine has three states: FETCH, OPA, OPB. The reset state is FETCH.
- FETCH (not stalled):
  - Latch Pipe0In into the opcode register.
  - Length 0: PipeOut=opcode, ImmOut=0, ImmValid=0; stay in FETCH.
  - Length >0: PipeOut=0x00, ImmValid=0, FetchSurpress=1; go to OPA.
- OPA:
  - Imm[7:0]=MEMDATA.
  - Length 1: PipeOut=opcode, ImmOut={8'h00,MEMDATA}, ImmValid=1, FetchSurpress=0; go to FETCH.
  - Length 2: PipeOut=0x00, FetchSurpress stays 1; go to OPB.
- OPB:
  - ImmOut={MEMDATA,Imm[7:0]}, PipeOut=opcode, ImmValid=1, FetchSurpress=0; go to FETCH.
- Pipe0In is ignored in OPA and OPB.
- BusRequest=1: the state, opcode, immediate and all outputs hold.
- Flush=1: next state is FETCH; PipeOut=0x00, ImmOut=0, ImmValid=0, FetchSurpress=0; the partial immediate is discarded.
- Flush has priority over BusRequest.

## Timing
- All outputs are registered.
- Reset values: PipeOut=0x00, ImmOut=0x0000, Pipe1Out_ImmValid=0, FetchSurpress=0, state=FETCH, internal opcode/imm=0.
- Latency from opcode capture to emission: 1 cycle for length 0, 2 cycles for length 1, 3 cycles for length 2. Each stall cycle adds 1.
- A completed instruction is visible for exactly one non-stalled cycle. PipeOut returns to 0x00 on the next advancing edge unless another length-0 opcode completes.
- FetchSurpress rises on the same edge that leaves FETCH for OPA, and falls on the edge that completes the final operand. Stage 0 sees it one cycle before the operand fetch.
- Back-to-back length-0 opcodes give one instruction per cycle with no bubble.
- Reset asserted mid-operand: immediate return to reset values. No instruction is emitted and FetchSurpress drops asynchronously.

## Configuration
- PIPE1_FLUSH_EN defined: Flush behaves as described above.
- PIPE1_FLUSH_EN undefined:
  - The Flush port remains but is ignored.
  - The state machine advances only on BusRequest=0.
  - The flush-priority logic is absent.

## Structure
- Shared package pipeline_pkg holds:
  - NOP opcode constant 8'h00.
  - Stage-1 state enum {FETCH, OPA, OPB}.
  - Operand-length type (2 bits) and the opcode[7:6] length-decode function.
- One sub-module: pipe1_oplen_decode (combinational, opcode to operand count), shared later with stage 2.
- Everything else is a single always block plus output registers in pipeline_stage1.

## Test plan
- Reset with ResetIn_n=0: all outputs read zero and the state is FETCH. Release reset with Pipe0In=0x12: next edge gives PipeOut=0x12, ImmValid=0, ImmOut=0x0000.
- Pipe0In=0x85, then MEMDATA=0x3C:
  - Edge 1: PipeOut=0x00, FetchSurpress=1.
  - Edge 2: PipeOut=0x85, ImmOut=0x003C, ImmValid=1, FetchSurpress=0.
- Pipe0In=0xC4, MEMDATA=0x34 then 0x12:
  - FetchSurpress is high for 2 cycles.
  - Edge 3: PipeOut=0xC4, ImmOut=0x1234, ImmValid=1.
- The 0xC4 sequence with BusRequest=1 for 2 cycles while in OPA: outputs frozen, operand sampled only after release, emission 2 cycles later with ImmOut=0x1234.
- With PIPE1_FLUSH_EN, Flush=1 while in OPB (BusRequest=1 too): next edge gives state FETCH, PipeOut=0x00, ImmValid=0, FetchSurpress=0. A following Pipe0In=0x01 is emitted normally.
- Reset pulse while in OPA after 0x85: FetchSurpress drops without waiting for ClockIn, and 0x85 is never emitted.
